// File: rtl/resample_sched_pkg.sv
// Shared types and helpers for the resample pop scheduler: FSM encoding,
// minimum usable frame period and the masked-channel search.
package resample_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } sched_state_t;

  localparam int MIN_PERIOD = 2;
  localparam int MAX_CH     = 32;

  // Lowest set bit of mask at or above 'from'; -1 when none remains.
  function automatic int next_ch(input logic [MAX_CH-1:0] mask, input int from);
    int idx;
    idx = -1;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/resample_frame_timer.sv
// Output-rate frame timer: latches the period at each wrap (and on enable),
// counts 0..P-1 and emits a registered pulse while the count is 0.
module resample_frame_timer
  import resample_sched_pkg::*;
#(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                frame
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] per;
  logic                run;
  logic                active;

  assign active = en && (period >= PERIOD_W'(MIN_PERIOD));

  // The enabling cycle counts as count 0, so the first pulse lands P cycles later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      per   <= '0;
      run   <= 1'b0;
      frame <= 1'b0;
    end else if (!active) begin
      cnt   <= '0;
      run   <= 1'b0;
      frame <= 1'b0;
    end else if (!run) begin
      run   <= 1'b1;
      per   <= period;
      cnt   <= PERIOD_W'(1);
      frame <= 1'b0;
    end else if (cnt == per - PERIOD_W'(1)) begin
      cnt   <= '0;
      per   <= period;
      frame <= 1'b1;
    end else begin
      cnt   <= cnt + PERIOD_W'(1);
      frame <= 1'b0;
    end
  end

endmodule

// File: rtl/resample_pop_sched.sv
// Per-frame pop sequencer for the resample pipeline with deadline tracking.
// Optional per-channel underrun counters: define RESAMPLE_SCHED_STATS_EN.
//
// state    | meaning
// IDLE     | waiting for a frame tick
// ISSUE    | pop strobe on cur_ch this cycle
// WAIT_ACK | waiting for ack_i[cur_ch]
module resample_pop_sched
  import resample_sched_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int NUM_CH_LOG2 = 1,
  parameter int PERIOD_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [PERIOD_W-1:0]    period_i,
  input  logic [NUM_CH-1:0]      ch_mask_i,
  input  logic [NUM_CH-1:0]      ack_i,
  input  logic                   underrun_clr_i,
  output logic [NUM_CH-1:0]      pop_o,
  output logic                   frame_o,
  output logic                   busy_o,
  output logic [NUM_CH_LOG2-1:0] cur_ch_o,
  output logic [NUM_CH-1:0]      underrun_o
`ifdef RESAMPLE_SCHED_STATS_EN
  , output logic [16*NUM_CH-1:0] underrun_cnt_o
`endif
);

  sched_state_t            state, state_nxt;
  logic [NUM_CH_LOG2-1:0]  cur_ch, cur_nxt;
  logic [NUM_CH-1:0]       mask_q, mask_nxt;
  logic [NUM_CH-1:0]       underrun;
  logic [NUM_CH-1:0]       miss_set;
  logic [NUM_CH-1:0]       pop;
  logic                    tick;
  int                      lo_ch;
  int                      nx_ch;

  resample_frame_timer #(
    .PERIOD_W(PERIOD_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (en_i),
    .period (period_i),
    .frame  (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cur_ch   <= '0;
      mask_q   <= '0;
      underrun <= '0;
    end else begin
      state    <= state_nxt;
      cur_ch   <= cur_nxt;
      mask_q   <= mask_nxt;
      underrun <= (underrun_clr_i ? '0 : underrun) | miss_set;
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_ch;
    mask_nxt  = mask_q;
    pop       = '0;
    miss_set  = '0;
    lo_ch     = next_ch(MAX_CH'(ch_mask_i), 0);
    nx_ch     = next_ch(MAX_CH'(mask_q), int'(cur_ch) + 1);

    if (state == ISSUE) pop[cur_ch] = 1'b1;

    case (state)
      IDLE: begin
        if (tick) begin
          mask_nxt = ch_mask_i;
          if (lo_ch >= 0) begin
            state_nxt = ISSUE;
            cur_nxt   = NUM_CH_LOG2'(lo_ch);
          end
        end
      end
      ISSUE: state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (ack_i[cur_ch]) begin
          if (nx_ch >= 0) begin
            state_nxt = ISSUE;
            cur_nxt   = NUM_CH_LOG2'(nx_ch);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Missed deadline: flag the served channel and every later one still owed
    // a pop, then restart the sequence on this same tick.
    if (tick && state != IDLE) begin
      miss_set[cur_ch] = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (mask_q[i] && i > int'(cur_ch)) miss_set[i] = 1'b1;
      end
      mask_nxt = ch_mask_i;
      if (lo_ch >= 0) begin
        state_nxt = ISSUE;
        cur_nxt   = NUM_CH_LOG2'(lo_ch);
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  assign pop_o      = pop;
  assign frame_o    = tick;
  assign busy_o     = (state != IDLE);
  assign cur_ch_o   = cur_ch;
  assign underrun_o = underrun;

`ifdef RESAMPLE_SCHED_STATS_EN
  logic [15:0] ucnt [NUM_CH];

  // A clear coinciding with an event leaves a count of one, matching the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) ucnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (underrun_clr_i) ucnt[i] <= miss_set[i] ? 16'd1 : 16'd0;
        else if (miss_set[i] && ucnt[i] != 16'hffff) ucnt[i] <= ucnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    underrun_cnt_o = '0;
    for (int i = 0; i < NUM_CH; i++) underrun_cnt_o[16*i +: 16] = ucnt[i];
  end
`else
  // Without statistics only the sticky flags record deadline misses.
`endif

endmodule

// File: tb/tb_resample_pop_sched.sv
// Directed bench for resample_pop_sched with a small ack-delay pipeline model.
module tb_resample_pop_sched;

  logic       clk;
  logic       rst;
  logic       en_i;
  logic [7:0] period_i;
  logic [1:0] ch_mask_i;
  logic [1:0] ack_i;
  logic       underrun_clr_i;
  logic [1:0] pop_o;
  logic       frame_o;
  logic       busy_o;
  logic [0:0] cur_ch_o;
  logic [1:0] underrun_o;
`ifdef RESAMPLE_SCHED_STATS_EN
  logic [31:0] underrun_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int dly [2];
  int cd  [2];

  resample_pop_sched dut (
    .clk            (clk),
    .rst            (rst),
    .en_i           (en_i),
    .period_i       (period_i),
    .ch_mask_i      (ch_mask_i),
    .ack_i          (ack_i),
    .underrun_clr_i (underrun_clr_i),
    .pop_o          (pop_o),
    .frame_o        (frame_o),
    .busy_o         (busy_o),
    .cur_ch_o       (cur_ch_o),
    .underrun_o     (underrun_o)
`ifdef RESAMPLE_SCHED_STATS_EN
    , .underrun_cnt_o (underrun_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pipeline model: ack a channel dly[ch] cycles after its pop.
  initial begin
    cd[0] = 0;
    cd[1] = 0;
    ack_i = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        ack_i[c] = 1'b0;
        if (cd[c] > 0) begin
          cd[c] = cd[c] - 1;
          if (cd[c] == 0) ack_i[c] = 1'b1;
        end
        if (pop_o[c] === 1'b1) cd[c] = dly[c];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_o !== 1'b1 && n < limit);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en_i = 1'b0;
    period_i = 8'd64;
    ch_mask_i = 2'b11;
    underrun_clr_i = 1'b0;
    dly[0] = 3;
    dly[1] = 3;
    repeat (3) step();
    checks++; if (pop_o !== 2'b00) begin failures++; $display("FAIL reset_pop: got %b want 00", pop_o); end
    checks++; if (frame_o !== 1'b0) begin failures++; $display("FAIL reset_frame: got %b want 0", frame_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (cur_ch_o !== 1'b0) begin failures++; $display("FAIL reset_cur_ch: got %b want 0", cur_ch_o); end
    checks++; if (underrun_o !== 2'b00) begin failures++; $display("FAIL reset_underrun: got %b want 00", underrun_o); end
    rst = 1'b1;
    repeat (3) step();
    checks++; if (busy_o !== 1'b0 || frame_o !== 1'b0) begin failures++; $display("FAIL disabled_idle: busy %b frame %b want 0 0", busy_o, frame_o); end
  endtask

  task automatic test_two_channels();
    int n;
    logic [1:0] exp_pop;
    en_i = 1'b1;
    wait_frame(200, n);
    checks++; if (n != 64) begin failures++; $display("FAIL first_frame: got %0d cycles want 64", n); end
    for (int o = 1; o <= 9; o++) begin
      step();
      exp_pop = (o == 1) ? 2'b01 : (o == 5) ? 2'b10 : 2'b00;
      checks++; if (pop_o !== exp_pop) begin failures++; $display("FAIL pop_seq off %0d: got %b want %b", o, pop_o, exp_pop); end
      if (o == 1) begin
        checks++; if (frame_o !== 1'b0 || busy_o !== 1'b1 || cur_ch_o !== 1'b0) begin failures++; $display("FAIL seq_start: frame %b busy %b cur %b want 0 1 0", frame_o, busy_o, cur_ch_o); end
      end
      if (o == 5) begin
        checks++; if (cur_ch_o !== 1'b1) begin failures++; $display("FAIL seq_cur_ch1: got %b want 1", cur_ch_o); end
      end
      if (o == 9) begin
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL seq_done_busy: got %b want 0", busy_o); end
      end
    end
    wait_frame(200, n);
    checks++; if (n != 55) begin failures++; $display("FAIL frame_period_64: got %0d want 55 after offset 9", n); end
    checks++; if (underrun_o !== 2'b00) begin failures++; $display("FAIL no_underrun: got %b want 00", underrun_o); end
  endtask

  task automatic test_single_channel();
    int n;
    logic [1:0] exp_pop;
    ch_mask_i = 2'b10;
    for (int o = 1; o <= 6; o++) begin
      step();
      exp_pop = (o == 1) ? 2'b10 : 2'b00;
      checks++; if (pop_o !== exp_pop) begin failures++; $display("FAIL mask10_pop off %0d: got %b want %b", o, pop_o, exp_pop); end
      if (o == 1) begin
        checks++; if (cur_ch_o !== 1'b1 || busy_o !== 1'b1) begin failures++; $display("FAIL mask10_start: cur %b busy %b want 1 1", cur_ch_o, busy_o); end
      end
      if (o == 5) begin
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL mask10_done: busy %b want 0", busy_o); end
      end
      if (o == 6) begin
        checks++; if (cur_ch_o !== 1'b1) begin failures++; $display("FAIL mask10_cur_hold: got %b want 1", cur_ch_o); end
      end
    end
    wait_frame(200, n);
    checks++; if (n != 58) begin failures++; $display("FAIL mask10_period: got %0d want 58", n); end
  endtask

  task automatic test_period_change();
    int n;
    ch_mask_i = 2'b11;
    repeat (10) step();
    period_i = 8'd32;
    wait_frame(200, n);
    checks++; if (n != 54) begin failures++; $display("FAIL period_cur_frame: got %0d want 54", n); end
    wait_frame(200, n);
    checks++; if (n != 32) begin failures++; $display("FAIL period_next_frame: got %0d want 32", n); end
    checks++; if (underrun_o !== 2'b00) begin failures++; $display("FAIL period_underrun: got %b want 00", underrun_o); end
  endtask

  task automatic test_deadline();
    int n;
    dly[1] = 20;
    period_i = 8'd8;
    wait_frame(200, n);
    checks++; if (n != 32) begin failures++; $display("FAIL dl_last32: got %0d want 32", n); end
    checks++; if (underrun_o !== 2'b00) begin failures++; $display("FAIL dl_f1_underrun: got %b want 00", underrun_o); end
    wait_frame(200, n);
    checks++; if (n != 8) begin failures++; $display("FAIL dl_period8: got %0d want 8", n); end
    step();
    checks++; if (underrun_o !== 2'b10 || pop_o !== 2'b01 || cur_ch_o !== 1'b0) begin failures++; $display("FAIL dl_f2: underrun %b pop %b cur %b want 10 01 0", underrun_o, pop_o, cur_ch_o); end
`ifdef RESAMPLE_SCHED_STATS_EN
    checks++; if (underrun_cnt !== 32'h0001_0000) begin failures++; $display("FAIL dl_cnt_f2: got %h want 00010000", underrun_cnt); end
`endif
    wait_frame(200, n);
    checks++; if (n != 7) begin failures++; $display("FAIL dl_f3_wait: got %0d want 7", n); end
    step();
    checks++; if (underrun_o !== 2'b10) begin failures++; $display("FAIL dl_f3: underrun %b want 10", underrun_o); end
`ifdef RESAMPLE_SCHED_STATS_EN
    checks++; if (underrun_cnt !== 32'h0002_0000) begin failures++; $display("FAIL dl_cnt_f3: got %h want 00020000", underrun_cnt); end
`endif
    step();
    dly[0] = 20;
    underrun_clr_i = 1'b1;
    step();
    underrun_clr_i = 1'b0;
    checks++; if (underrun_o !== 2'b00) begin failures++; $display("FAIL dl_clear: underrun %b want 00", underrun_o); end
`ifdef RESAMPLE_SCHED_STATS_EN
    checks++; if (underrun_cnt !== 32'h0) begin failures++; $display("FAIL dl_cnt_clear: got %h want 0", underrun_cnt); end
`endif
    wait_frame(200, n);
    step();
    checks++; if (underrun_o !== 2'b10) begin failures++; $display("FAIL dl_f4: underrun %b want 10", underrun_o); end
    step();
    dly[0] = 3;
    wait_frame(200, n);
    step();
    checks++; if (underrun_o !== 2'b11 || pop_o !== 2'b01) begin failures++; $display("FAIL dl_f5_both: underrun %b pop %b want 11 01", underrun_o, pop_o); end
`ifdef RESAMPLE_SCHED_STATS_EN
    checks++; if (underrun_cnt !== 32'h0002_0001) begin failures++; $display("FAIL dl_cnt_f5: got %h want 00020001", underrun_cnt); end
`endif
    wait_frame(200, n);
    underrun_clr_i = 1'b1;
    step();
    underrun_clr_i = 1'b0;
    checks++; if (underrun_o !== 2'b10) begin failures++; $display("FAIL dl_set_wins: underrun %b want 10", underrun_o); end
`ifdef RESAMPLE_SCHED_STATS_EN
    checks++; if (underrun_cnt !== 32'h0001_0000) begin failures++; $display("FAIL dl_cnt_set_wins: got %h want 00010000", underrun_cnt); end
`endif
  endtask

  task automatic test_async_reset();
    int n;
    dly[1] = 3;
    wait_frame(200, n);
    repeat (6) step();
    checks++; if (busy_o !== 1'b1 || cur_ch_o !== 1'b1 || underrun_o !== 2'b10) begin failures++; $display("FAIL pre_reset: busy %b cur %b underrun %b want 1 1 10", busy_o, cur_ch_o, underrun_o); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || cur_ch_o !== 1'b0 || underrun_o !== 2'b00 || pop_o !== 2'b00 || frame_o !== 1'b0) begin
      failures++; $display("FAIL async_reset: busy %b cur %b underrun %b pop %b frame %b want all 0", busy_o, cur_ch_o, underrun_o, pop_o, frame_o);
    end
    en_i = 1'b0;
    period_i = 8'd1;
    step();
    rst = 1'b1;
    en_i = 1'b1;
    wait_frame(40, n);
    checks++; if (n != 40 || frame_o === 1'b1) begin failures++; $display("FAIL period1_no_frame: got %0d cycles frame %b want 40 0", n, frame_o); end
    period_i = 8'd16;
    wait_frame(40, n);
    checks++; if (n != 16) begin failures++; $display("FAIL post_reset_first_frame: got %0d want 16", n); end
  endtask

  task automatic test_disable();
    int n;
    logic [1:0] exp_pop;
    step();
    checks++; if (pop_o !== 2'b01) begin failures++; $display("FAIL dis_issue0: pop %b want 01", pop_o); end
    en_i = 1'b0;
    for (int o = 2; o <= 9; o++) begin
      step();
      exp_pop = (o == 5) ? 2'b10 : 2'b00;
      checks++; if (pop_o !== exp_pop) begin failures++; $display("FAIL dis_pop off %0d: got %b want %b", o, pop_o, exp_pop); end
    end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL dis_done: busy %b want 0", busy_o); end
    wait_frame(60, n);
    checks++; if (n != 60 || frame_o === 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL dis_no_frame: cycles %0d frame %b busy %b want 60 0 0", n, frame_o, busy_o); end
  endtask

  initial begin
    test_reset();
    test_two_channels();
    test_single_channel();
    test_period_change();
    test_deadline();
    test_async_reset();
    test_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
